// File: rtl/multi_btn_detector.sv
// N-channel push-button conditioner: 2-FF sync, shift-register debounce with hysteresis,
// registered edge pulses, long-press detection and hold-to-repeat, sharing one sample-tick prescaler.
module multi_btn_detector #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned CLK_DIV      = 100_000,
    parameter int unsigned DEB_DEPTH    = 8,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] rising_edge,
    output logic [N_BTN-1:0] falling_edge,
    output logic [N_BTN-1:0] both_edge,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_pulse
);

    localparam int unsigned DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HOLD_W = ($clog2(LONG_TICKS + 1) > 1) ? $clog2(LONG_TICKS + 1) : 1;
    localparam int unsigned REP_W  = ($clog2(REPEAT_TICKS + 1) > 1) ? $clog2(REPEAT_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit                REP_EN    = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } hold_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    // Shared prescaler; tick is a one-clk strobe the cycle after the count wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [DEB_DEPTH-1:0] shreg;
        logic                 all_one_c;
        logic                 all_zero_c;
        logic                 rise_c;
        logic                 fall_c;
        logic                 level_q;
        logic                 rise_q;
        logic                 fall_q;
        logic                 both_q;
        logic                 long_q;
        logic                 rep_q;
        hold_state_t          state;
        logic [HOLD_W-1:0]    hold_cnt;
        logic [REP_W-1:0]     rep_cnt;

        // Newest sample enters at the MSB
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shreg <= '0;
            end else if (tick) begin
                shreg <= {sync2[g], shreg[DEB_DEPTH-1:1]};
            end
        end

        assign all_one_c  = &shreg;
        assign all_zero_c = ~|shreg;
        assign rise_c     = all_one_c & ~level_q;
        assign fall_c     = all_zero_c & level_q;

        // Hysteresis: a mixed register holds the previous level
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                both_q  <= 1'b0;
            end else begin
                if (rise_c) begin
                    level_q <= 1'b1;
                end else if (fall_c) begin
                    level_q <= 1'b0;
                end
                rise_q <= rise_c;
                fall_q <= fall_c;
                both_q <= rise_c | fall_c;
            end
        end

        // Hold/repeat FSM; a falling level overrides everything and suppresses pulses
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                long_q   <= 1'b0;
                rep_q    <= 1'b0;
            end else begin
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                if (fall_c) begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise_c) begin
                                state    <= ST_HOLD;
                                hold_cnt <= '0;
                                rep_cnt  <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (tick && level_q) begin
                                if (hold_cnt == HOLD_LAST) begin
                                    hold_cnt <= HOLD_MAX;
                                    long_q   <= 1'b1;
                                    if (REP_EN) begin
                                        state   <= ST_REPEAT;
                                        rep_cnt <= '0;
                                    end
                                end else if (hold_cnt != HOLD_MAX) begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (tick) begin
                                if (rep_cnt == REP_LAST) begin
                                    rep_cnt <= '0;
                                    rep_q   <= 1'b1;
                                end else begin
                                    rep_cnt <= rep_cnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                            rep_cnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[g]        = level_q;
        assign rising_edge[g]  = rise_q;
        assign falling_edge[g] = fall_q;
        assign both_edge[g]    = both_q;
        assign long_press[g]   = long_q;
        assign repeat_pulse[g] = rep_q;
    end

endmodule

// File: tb/tb_multi_btn_detector.sv
// Directed bench for multi_btn_detector: CLK_DIV=4, DEB_DEPTH=3, LONG_TICKS=5, REPEAT_TICKS=2,
// plus a REPEAT_TICKS=0 instance sharing the same stimulus.
module tb_multi_btn_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;

    logic [1:0] level, rising_edge, falling_edge, both_edge, long_press, repeat_pulse;
    logic [1:0] nr_level, nr_rise, nr_fall, nr_both, nr_long_o, nr_rep_o;
    logic [11:0] outs;

    assign outs = {level, rising_edge, falling_edge, both_edge, long_press, repeat_pulse};

    multi_btn_detector #(
        .N_BTN(2), .CLK_DIV(4), .DEB_DEPTH(3), .LONG_TICKS(5), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .level(level), .rising_edge(rising_edge), .falling_edge(falling_edge),
        .both_edge(both_edge), .long_press(long_press), .repeat_pulse(repeat_pulse)
    );

    multi_btn_detector #(
        .N_BTN(2), .CLK_DIV(4), .DEB_DEPTH(3), .LONG_TICKS(5), .REPEAT_TICKS(0)
    ) dut_nr (
        .clk(clk), .reset(reset), .btn(btn),
        .level(nr_level), .rising_edge(nr_rise), .falling_edge(nr_fall),
        .both_edge(nr_both), .long_press(nr_long_o), .repeat_pulse(nr_rep_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rise[2], n_fall[2], n_long[2], n_rep[2], nr_long[2], nr_rep[2];
    int wide = 0, both_bad = 0, tick_wide = 0;
    int rise_cyc, long_cyc, rep1_cyc, rep2_cyc;
    int tick_prev = 0, tick_last = 0;
    logic [1:0] p_rise = '0, p_fall = '0, p_long = '0, p_rep = '0;
    logic p_tick = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 2; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            nr_long[c] = 0; nr_rep[c] = 0;
        end
        rise_cyc = 0; long_cyc = 0; rep1_cyc = 0; rep2_cyc = 0;
    endtask

    function automatic int total();
        int s = 0;
        for (int c = 0; c < 2; c++) s += n_rise[c] + n_fall[c] + n_long[c] + n_rep[c];
        return s;
    endfunction

    // One clock: sample just after the edge and accumulate pulse statistics
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (rising_edge[c])  n_rise[c]++;
            if (falling_edge[c]) n_fall[c]++;
            if (long_press[c])   n_long[c]++;
            if (repeat_pulse[c]) n_rep[c]++;
            if (nr_long_o[c])    nr_long[c]++;
            if (nr_rep_o[c])     nr_rep[c]++;
        end
        if (rising_edge[0]) rise_cyc = cyc;
        if (long_press[0])  long_cyc = cyc;
        if (repeat_pulse[0]) begin
            if (n_rep[0] == 1) rep1_cyc = cyc;
            else if (n_rep[0] == 2) rep2_cyc = cyc;
        end
        if (((rising_edge & p_rise) | (falling_edge & p_fall) |
             (long_press & p_long) | (repeat_pulse & p_rep)) != 2'b00) wide++;
        if (both_edge != (rising_edge | falling_edge)) both_bad++;
        if (dut.tick) begin
            if (p_tick) tick_wide++;
            tick_prev = tick_last;
            tick_last = cyc;
        end
        p_rise = rising_edge; p_fall = falling_edge;
        p_long = long_press;  p_rep  = repeat_pulse;
        p_tick = dut.tick;
    endtask

    initial begin
        int rc;
        int got;
        reset = 1'b1;
        btn   = 2'b00;
        clr();
        repeat (3) @(negedge clk);
        check("rst_outs", int'(outs), 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        clr();
        for (int i = 0; i < 100; i++) step();
        check("idle_pulses", total(), 0);
        check("idle_level", int'(level), 0);
        check("tick_period", tick_last - tick_prev, 4);
        check("tick_width", tick_wide, 0);

        // Press channel 0 and hold for 20 ticks past the rise
        clr();
        btn = 2'b01;
        got = cyc;
        for (int i = 0; i < 20 && n_rise[0] == 0; i++) step();
        check("rise0_seen", n_rise[0], 1);
        check("rise0_latency_ok", int'((rise_cyc - got) <= 15 && rise_cyc > got), 1);
        rc = rise_cyc;
        while (cyc < rc + 80) step();
        check("level0_held", int'(level), 1);
        check("rise0_count", n_rise[0], 1);
        check("ch1_silent", n_rise[1] + n_fall[1] + n_long[1] + n_rep[1], 0);
        check("long_count", n_long[0], 1);
        check("long_delay", long_cyc - rc, 19);
        check("rep_first", rep1_cyc - long_cyc, 8);
        check("rep_period", rep2_cyc - rep1_cyc, 8);
        check("rep_count", n_rep[0], 7);

        // Release: one falling edge, then silence
        btn = 2'b00;
        clr();
        for (int i = 0; i < 20; i++) step();
        check("fall0_count", n_fall[0], 1);
        check("level0_low", int'(level), 0);
        clr();
        for (int i = 0; i < 40; i++) step();
        check("quiet_after_release", total(), 0);

        // Bounce: toggle every 3 clk for 40 clk, then steady high
        clr();
        for (int i = 0; i < 40; i++) begin
            btn[0] = (((i / 3) % 2) == 0);
            step();
        end
        check("bounce_no_rise", n_rise[0], 0);
        btn = 2'b01;
        for (int i = 0; i < 20; i++) step();
        check("bounce_rise", n_rise[0], 1);
        check("bounce_fall", n_fall[0], 0);
        btn = 2'b00;
        for (int i = 0; i < 30; i++) step();

        // Release after 4 counted ticks: no long press, re-press restarts count
        clr();
        btn = 2'b01;
        for (int i = 0; i < 20 && n_rise[0] == 0; i++) step();
        check("short_rise_seen", n_rise[0], 1);
        rc = rise_cyc;
        while (cyc < rc + 4) step();
        btn = 2'b00;
        for (int i = 0; i < 20; i++) step();
        check("short_no_long", n_long[0], 0);
        check("short_fall", n_fall[0], 1);
        clr();
        btn = 2'b01;
        for (int i = 0; i < 20 && n_rise[0] == 0; i++) step();
        check("repress_rise_seen", n_rise[0], 1);
        rc = rise_cyc;
        while (cyc < rc + 20) step();
        check("repress_long_delay", long_cyc - rc, 19);
        btn = 2'b00;
        for (int i = 0; i < 30; i++) step();

        // Both channels together, then reset mid-repeat
        clr();
        btn = 2'b11;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin step(); got = int'(rising_edge); end
        check("sim_rise", got, 3);
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin step(); got = int'(long_press); end
        check("sim_long", got, 3);
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin step(); got = int'(repeat_pulse); end
        check("sim_rep", got, 3);
        step(); step(); step();
        reset = 1'b1;
        #1;
        check("rst_mid_outs", int'(outs), 0);
        for (int i = 0; i < 3; i++) step();
        check("rst_hold_outs", int'(outs), 0);
        @(negedge clk);
        reset = 1'b0;
        clr();
        got = 0;
        for (int i = 0; i < 25 && got == 0; i++) begin step(); got = int'(rising_edge); end
        check("post_rst_rise", got, 3);
        check("post_rst_no_other", n_fall[0] + n_fall[1] + n_long[0] + n_long[1] + n_rep[0] + n_rep[1], 0);
        btn = 2'b00;
        for (int i = 0; i < 30; i++) step();

        // 30-tick hold on the repeat-disabled instance
        clr();
        btn = 2'b01;
        for (int i = 0; i < 140; i++) step();
        check("nr_long_count", nr_long[0], 1);
        check("nr_rep_count", nr_rep[0] + nr_rep[1], 0);
        btn = 2'b00;
        for (int i = 0; i < 30; i++) step();

        check("pulse_width", wide, 0);
        check("both_is_or", both_bad, 0);
        check("tick_width_end", tick_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
